// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side controller for a UART deserializer.
//   - Generates the 16x oversample enable (tick16) from a programmable divisor.
//   - Buffers bytes strobed in by the deserializer into a small show-ahead FIFO.
//   - Presents the FIFO head to the host over a valid/ready handshake.
//   - Flags overrun (sticky) when a byte arrives with the FIFO full.
//   - Optional idle timeout: compile with `define UART_RX_TIMEOUT_EN to build
//     the timeout counter; otherwise timeout_irq is tied to 0.
//
// Parameters:
//   FIFO_DEPTH    byte entries, power of two, >= 2
//   DIV_W         width of the baud divisor
//   TIMEOUT_CHARS idle character times (x160 tick16 pulses) before timeout
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   enable        receiver enable (divider runs, pushes accepted)
//   baud_div      tick16 period = baud_div + 1 clocks
//   tick16        one-clock oversample enable (registered)
//   rx_data/valid byte strobe from the deserializer
//   rd_data/valid FIFO head byte / FIFO not empty
//   rd_ready      host accepts the head byte
//   fifo_count    FIFO occupancy
//   overrun       sticky byte-dropped flag, cleared by clr_overrun
//   timeout_irq   idle timeout with data pending (level, registered)
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int DIV_W         = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          tick16,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          timeout_irq
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    // ------------------------------------------------------------------
    // Oversample divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_tick16;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    // A counter already above a newly lowered baud_div runs on until it
    // wraps at 2^DIV_W and meets the compare again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_tick16  <= 1'b0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_tick16  <= 1'b0;
        end else if (r_div_cnt == baud_div) begin
            r_div_cnt <= '0;
            r_tick16  <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_tick16  <= 1'b0;
        end
    end

    assign tick16 = r_tick16;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = !w_empty && rd_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push  = rx_valid && enable && (!w_full || w_pop);
    assign w_drop  = rx_valid && enable && w_full && !w_pop;

    // NOTE: the storage array has no reset; only pointers and count do, and
    // rd_data is masked while empty, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority so a drop coinciding with a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_valid   = !w_empty;
    assign rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign overrun    = r_overrun;

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_MAX = TIMEOUT_CHARS * 160;
    localparam int TO_W   = $clog2(TO_MAX + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_next;
    logic            r_timeout_irq;

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_to_next = r_to_cnt;
        if (w_push || w_pop || w_empty) begin
            w_to_next = '0;
        end else if (r_tick16 && (r_to_cnt != TO_W'(TO_MAX))) begin
            w_to_next = r_to_cnt + 1'b1;
        end
    end

    // The flag is registered from the next count, so it rises the cycle after
    // the saturating tick and falls the cycle after a clearing push or pop.
    // A saturated next count implies the FIFO stays non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_timeout_irq <= 1'b0;
        end else begin
            r_to_cnt      <= w_to_next;
            r_timeout_irq <= (w_to_next == TO_W'(TO_MAX));
        end
    end

    assign timeout_irq = r_timeout_irq;
`else
    assign timeout_irq = 1'b0;
`endif

endmodule
